// File: rtl/e203_nice_csr_pkg.sv
// Shared constants and types for the NICE CSR responder.
// Holds the register indices, the CSR window nibble and the FSM state type.
package e203_nice_csr_pkg;

  localparam logic [7:0] IDX_CTRL     = 8'd0;
  localparam logic [7:0] IDX_STAT     = 8'd1;
  localparam logic [7:0] IDX_BCYC     = 8'd2;
  localparam int         IDX_SCR_BASE = 3;

  localparam logic [3:0] CSR_WINDOW = 4'hE;
  localparam int         ILLW_BIT   = 31;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } csr_state_e;

endpackage

// File: rtl/e203_nice_csr_resp.sv
// NICE CSR slave: a small register bank in the 0xE00-0xEFF window with zero-latency reads.
// It throttles the core while the accelerator is busy or a post-write settle interval runs.
module e203_nice_csr_resp
  import e203_nice_csr_pkg::*;
#(
  parameter int CSR_NUM  = 8,
  parameter int WR_STALL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nice_csr_valid,
  output logic        nice_csr_ready,
  input  logic [31:0] nice_csr_addr,
  input  logic        nice_csr_wr,
  input  logic [31:0] nice_csr_wdata,
  output logic [31:0] nice_csr_rdata,
  input  logic        nice_busy,
  input  logic [31:0] nice_stat,
  output logic [31:0] nice_ctrl,
  output csr_state_e  csr_state
);

  // Handshake: a transfer happens only in a cycle where valid and ready are both high.
  // Ready never depends on valid; the requester may withdraw valid at any time.
  logic [7:0]  idx;
  logic        hit;
  logic        wr_fire;
  logic        wr_legal;
  logic        wr_illegal;
  logic [31:0] ctrl_q;
  logic [31:0] bcyc_q;
  logic [31:0] scr_q [IDX_SCR_BASE:CSR_NUM-1];
  logic        unused_addr;

  assign idx         = nice_csr_addr[7:0];
  assign hit         = (nice_csr_addr[11:8] == CSR_WINDOW) && ({1'b0, idx} < 9'(CSR_NUM));
  assign unused_addr = ^nice_csr_addr[31:12];

  assign wr_fire    = nice_csr_valid & nice_csr_ready & nice_csr_wr;
  assign wr_legal   = wr_fire & hit & (idx != IDX_STAT);
  assign wr_illegal = wr_fire & ~(hit & (idx != IDX_STAT));

  assign nice_ctrl      = ctrl_q;
  assign nice_csr_ready = (csr_state == ST_IDLE) & ~nice_busy;

  always_comb begin
    nice_csr_rdata = '0;
    if (hit) begin
      case (idx)
        IDX_CTRL: nice_csr_rdata = ctrl_q;
        IDX_STAT: nice_csr_rdata = nice_stat;
        IDX_BCYC: nice_csr_rdata = bcyc_q;
        default: begin
          for (int i = IDX_SCR_BASE; i < CSR_NUM; i++) begin
            if (idx == 8'(i)) nice_csr_rdata = scr_q[i];
          end
        end
      endcase
    end
  end

  // ILLW is sticky: hardware sets it, software can only clear it by writing a 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (wr_legal && idx == IDX_CTRL) begin
      ctrl_q[ILLW_BIT-1:0] <= nice_csr_wdata[ILLW_BIT-1:0];
      if (!nice_csr_wdata[ILLW_BIT]) ctrl_q[ILLW_BIT] <= 1'b0;
    end else if (wr_illegal) begin
      ctrl_q[ILLW_BIT] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcyc_q <= '0;
    end else if (wr_legal && idx == IDX_BCYC) begin
      bcyc_q <= nice_csr_wdata;
    end else if (nice_busy) begin
      bcyc_q <= bcyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = IDX_SCR_BASE; i < CSR_NUM; i++) scr_q[i] <= '0;
    end else begin
      for (int i = IDX_SCR_BASE; i < CSR_NUM; i++) begin
        if (wr_legal && idx == 8'(i)) scr_q[i] <= nice_csr_wdata;
      end
    end
  end

  generate
    if (WR_STALL > 0) begin : g_stall
      localparam int            CW   = $clog2(WR_STALL + 1);
      localparam logic [CW-1:0] LOAD = CW'(WR_STALL - 1);

      csr_state_e    state_q;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (wr_fire) begin
                state_q <= ST_STALL;
                cnt_q   <= LOAD;
              end
            end
            ST_STALL: begin
              if (cnt_q == '0) state_q <= ST_IDLE;
              else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end

      assign csr_state = state_q;
    end else begin : g_no_stall
      assign csr_state = ST_IDLE;
    end
  endgenerate

endmodule

// File: tb/tb_e203_nice_csr_resp.sv
// Bench for the NICE CSR responder: directed register-map scenarios plus random scratch data,
// with read results checked against an expected queue at the handshake cycle.
module tb_e203_nice_csr_resp;
  import e203_nice_csr_pkg::*;

  localparam int CSR_NUM  = 8;
  localparam int WR_STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic        busy = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] stat = 32'h0000_1234;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] ctrl;
  csr_state_e  st;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [CSR_NUM];

  e203_nice_csr_resp #(.CSR_NUM(CSR_NUM), .WR_STALL(WR_STALL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nice_csr_valid (valid),
    .nice_csr_ready (ready),
    .nice_csr_addr  (addr),
    .nice_csr_wr    (wr),
    .nice_csr_wdata (wdata),
    .nice_csr_rdata (rdata),
    .nice_busy      (busy),
    .nice_stat      (stat),
    .nice_ctrl      (ctrl),
    .csr_state      (st)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic csr_read(input logic [11:0] a, input logic [31:0] e);
    bit          ok;
    logic [31:0] exp;
    exp_q.push_back(e);
    valid = 1'b1;
    wr    = 1'b0;
    addr  = {20'b0, a};
    wait_ready(ok);
    exp = exp_q.pop_front();
    if (ok) check($sformatf("rd_%h", a), rdata, exp);
    step();
    valid = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bit ok;
    valid = 1'b1;
    wr    = 1'b1;
    addr  = {20'b0, a};
    wdata = d;
    wait_ready(ok);
    step();
    valid = 1'b0;
    wr    = 1'b0;
  endtask

  // ready must stay low for exactly WR_STALL cycles after an accepted write
  task automatic check_stall();
    for (int i = 0; i < WR_STALL; i++) begin
      @(negedge clk);
      check("stall_ready", {31'b0, ready}, 32'd0);
      step();
    end
    @(negedge clk);
    check("post_stall_ready", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < CSR_NUM; i++) mdl[i] = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_state", {31'b0, st}, {31'b0, ST_IDLE});
    csr_read(12'hE02, 32'h0);
    csr_read(12'hE01, 32'h0000_1234);
    stat = 32'hCAFE_0001;
    csr_read(12'hE01, 32'hCAFE_0001);

    csr_write(12'hE03, 32'hDEAD_BEEF);
    mdl[3] = 32'hDEAD_BEEF;
    check_stall();
    csr_read(12'hE03, 32'hDEAD_BEEF);

    for (int i = IDX_SCR_BASE; i < CSR_NUM; i++) begin
      mdl[i] = $urandom_range(32'hFFFF_FFFF, 0);
      csr_write(12'hE00 | 12'(i), mdl[i]);
      check_stall();
    end
    for (int i = IDX_SCR_BASE; i < CSR_NUM; i++) csr_read(12'hE00 | 12'(i), mdl[i]);

    // illegal writes: STAT, past the last register, outside the window
    csr_write(12'hE01, 32'h5);
    check_stall();
    csr_read(12'hE01, 32'hCAFE_0001);
    check("illw_stat", ctrl, 32'h8000_0000);
    csr_write(12'hE40, 32'hAA);
    check_stall();
    csr_read(12'hE40, 32'h0);
    csr_read(12'hE08, 32'h0);
    csr_read(12'hE07, mdl[7]);

    csr_write(12'hE00, 32'h8000_0003);
    check_stall();
    check("ctrl_w1_keeps", ctrl, 32'h8000_0003);
    csr_write(12'hE00, 32'h0000_0007);
    check_stall();
    check("ctrl_w0_clears", ctrl, 32'h0000_0007);
    csr_read(12'hE00, 32'h0000_0007);
    csr_write(12'hE00, 32'h8000_0005);
    check_stall();
    check("ctrl_cannot_set", ctrl, 32'h0000_0005);
    csr_write(12'hD03, 32'h1);
    check_stall();
    check("illw_window", ctrl, 32'h8000_0005);
    csr_read(12'hD03, 32'h0);

    // busy-cycle counter wrap
    csr_write(12'hE02, 32'hFFFF_FFFE);
    check_stall();
    step();
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_ready", {31'b0, ready}, 32'd0);
      step();
    end
    busy = 1'b0;
    csr_read(12'hE02, 32'h1);
    csr_write(12'hE02, 32'h10);
    check_stall();
    csr_read(12'hE02, 32'h10);

    // withdrawn write while busy: no register change, no stall
    step();
    busy  = 1'b1;
    valid = 1'b1;
    wr    = 1'b1;
    addr  = 32'hE04;
    wdata = 32'h5555;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("withdraw_ready", {31'b0, ready}, 32'd0);
      step();
    end
    valid = 1'b0;
    wr    = 1'b0;
    busy  = 1'b0;
    @(negedge clk);
    check("withdraw_state", {31'b0, st}, {31'b0, ST_IDLE});
    check("withdraw_ready_hi", {31'b0, ready}, 32'd1);
    csr_read(12'hE04, mdl[4]);
    csr_read(12'hE02, 32'h12);

    // busy rising inside STALL keeps ready low until both clear
    csr_write(12'hE05, 32'h77);
    busy = 1'b1;
    for (int i = 0; i < WR_STALL + 2; i++) begin
      @(negedge clk);
      check("stall_busy_ready", {31'b0, ready}, 32'd0);
      step();
    end
    busy = 1'b0;
    @(negedge clk);
    check("stall_busy_release", {31'b0, ready}, 32'd1);
    csr_read(12'hE05, 32'h77);

    // asynchronous reset in the middle of STALL
    csr_write(12'hE00, 32'h0000_0009);
    check_stall();
    csr_write(12'hE06, 32'h99);
    step();
    @(negedge clk);
    check("pre_rst_state", {31'b0, st}, {31'b0, ST_STALL});
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_state", {31'b0, st}, {31'b0, ST_IDLE});
    check("rst_mid_ctrl", ctrl, 32'h0);
    check("rst_mid_ready", {31'b0, ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", {31'b0, ready}, 32'd1);
    csr_read(12'hE06, 32'h0);
    csr_read(12'hE03, 32'h0);
    csr_read(12'hE02, 32'h0);
    csr_read(12'hE00, 32'h0);
    csr_read(12'hE01, 32'hCAFE_0001);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
